// File: rtl/axi_stream_comparator_multi.sv
// N-channel lockstep AXI-Stream checker: per-channel skew FIFOs, beat-wise compare against
// channel 0, transfer counting, first-mismatch capture and a stall watchdog.
module axi_stream_comparator_multi #(
  parameter int CHANNELS   = 2,
  parameter int DATA_BITS  = 32,
  parameter int COUNT_BITS = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           in_tvalid,
  output logic [CHANNELS-1:0]           in_tready,
  input  logic [CHANNELS*DATA_BITS-1:0] in_tdata,
  output logic                          transfer,
  output logic [COUNT_BITS-1:0]         transfer_count,
  output logic                          count_overflow,
  output logic                          transfer_mismatch,
  output logic                          transfer_mismatch_latch,
  output logic [$clog2(CHANNELS)-1:0]   mismatch_channel,
  output logic [COUNT_BITS-1:0]         mismatch_index,
  output logic [DATA_BITS-1:0]          mismatch_tdata_ref,
  output logic [DATA_BITS-1:0]          mismatch_tdata,
  output logic                          stall_timeout
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CH_BITS  = $clog2(CHANNELS);
  localparam logic [31:0]       TIMEOUT_W = 32'(TIMEOUT);
  localparam logic [PTR_BITS:0] DEPTH_W   = (PTR_BITS+1)'(DEPTH);

  logic [DATA_BITS-1:0] mem_r    [CHANNELS][DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr_r [CHANNELS];
  logic [PTR_BITS-1:0]  rd_ptr_r [CHANNELS];
  logic [PTR_BITS:0]    occ_r    [CHANNELS];
  logic [DATA_BITS-1:0] head_s   [CHANNELS];

  logic [CHANNELS-1:0]   full_s;
  logic [CHANNELS-1:0]   empty_s;
  logic [CHANNELS-1:0]   wr_en_s;
  logic                  pop_s;
  logic                  all_empty_s;
  logic                  diff_s;
  logic [CH_BITS-1:0]    diff_ch_s;
  logic [DATA_BITS-1:0]  diff_data_s;
  logic [COUNT_BITS-1:0] count_inc_s;
  logic [31:0]           idle_r;
  logic [31:0]           idle_next_s;

  // Ready depends only on registered occupancy and reset, never on in_tvalid.
  assign in_tready = ~full_s & {CHANNELS{~rst}};

  // FIFO status, heads, pop decision and lowest-index channel that disagrees with channel 0.
  always_comb begin
    diff_s      = 1'b0;
    diff_ch_s   = '0;
    diff_data_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      full_s[c]  = (occ_r[c] == DEPTH_W);
      empty_s[c] = (occ_r[c] == '0);
      head_s[c]  = mem_r[c][rd_ptr_r[c]];
    end
    pop_s       = ~|empty_s;
    all_empty_s = &empty_s;
    wr_en_s     = in_tvalid & ~full_s;
    count_inc_s = transfer_count + COUNT_BITS'(1);
    // Walk downwards so the last hit is the lowest differing channel.
    for (int c = CHANNELS - 1; c >= 1; c--) begin
      diff_ch_s   = (head_s[c] != head_s[0]) ? CH_BITS'(c) : diff_ch_s;
      diff_data_s = (head_s[c] != head_s[0]) ? head_s[c] : diff_data_s;
      diff_s      = diff_s | (head_s[c] != head_s[0]);
    end
  end

  // Watchdog next value: idle cycles while some but not all FIFOs hold data, saturating.
  always_comb begin
    if (pop_s || all_empty_s) begin
      idle_next_s = '0;
    end else if (idle_r != TIMEOUT_W) begin
      idle_next_s = idle_r + 32'd1;
    end else begin
      idle_next_s = idle_r;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_en_s[c]) begin
        mem_r[c][wr_ptr_r[c]] <= in_tdata[c*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // FIFO pointers and occupancy; a full FIFO refuses writes even when popping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_r[c] <= '0;
        rd_ptr_r[c] <= '0;
        occ_r[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wr_en_s[c]) begin
          wr_ptr_r[c] <= wr_ptr_r[c] + PTR_BITS'(1);
        end
        if (pop_s) begin
          rd_ptr_r[c] <= rd_ptr_r[c] + PTR_BITS'(1);
        end
        case ({wr_en_s[c], pop_s})
          2'b10:   occ_r[c] <= occ_r[c] + (PTR_BITS+1)'(1);
          2'b01:   occ_r[c] <= occ_r[c] - (PTR_BITS+1)'(1);
          default: occ_r[c] <= occ_r[c];
        endcase
      end
    end
  end

  // Registered results: pulses, counter, sticky flags and first-mismatch capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      transfer                <= 1'b0;
      transfer_count          <= '0;
      count_overflow          <= 1'b0;
      transfer_mismatch       <= 1'b0;
      transfer_mismatch_latch <= 1'b0;
      mismatch_channel        <= '0;
      mismatch_index          <= '0;
      mismatch_tdata_ref      <= '0;
      mismatch_tdata          <= '0;
      stall_timeout           <= 1'b0;
      idle_r                  <= '0;
    end else begin
      transfer          <= pop_s;
      transfer_mismatch <= pop_s & diff_s;
      idle_r            <= idle_next_s;
      if (idle_next_s == TIMEOUT_W) begin
        stall_timeout <= 1'b1;
      end
      if (pop_s) begin
        transfer_count <= count_inc_s;
        if (&transfer_count) begin
          count_overflow <= 1'b1;
        end
        if (diff_s && !transfer_mismatch_latch) begin
          transfer_mismatch_latch <= 1'b1;
          mismatch_channel        <= diff_ch_s;
          mismatch_index          <= count_inc_s;
          mismatch_tdata_ref      <= head_s[0];
          mismatch_tdata          <= diff_data_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_comparator_multi.sv
// Randomized bench for axi_stream_comparator_multi against a queue-based reference model.
module tb_axi_stream_comparator_multi;

  localparam int CH    = 3;
  localparam int DB    = 16;
  localparam int CB    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic              clk;
  logic              rst;
  logic [CH-1:0]     in_tvalid;
  logic [CH-1:0]     in_tready;
  logic [CH*DB-1:0]  in_tdata;
  logic              transfer;
  logic [CB-1:0]     transfer_count;
  logic              count_overflow;
  logic              transfer_mismatch;
  logic              transfer_mismatch_latch;
  logic [1:0]        mismatch_channel;
  logic [CB-1:0]     mismatch_index;
  logic [DB-1:0]     mismatch_tdata_ref;
  logic [DB-1:0]     mismatch_tdata;
  logic              stall_timeout;

  axi_stream_comparator_multi #(
    .CHANNELS(CH), .DATA_BITS(DB), .COUNT_BITS(CB), .DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .transfer(transfer), .transfer_count(transfer_count), .count_overflow(count_overflow),
    .transfer_mismatch(transfer_mismatch), .transfer_mismatch_latch(transfer_mismatch_latch),
    .mismatch_channel(mismatch_channel), .mismatch_index(mismatch_index),
    .mismatch_tdata_ref(mismatch_tdata_ref), .mismatch_tdata(mismatch_tdata),
    .stall_timeout(stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: one queue per channel plus the expected output values.
  int q[CH][$];
  int seq[CH];
  int dv[CH];
  int m_cnt, m_idle, m_ch, m_idx, m_ref, m_dat;
  bit m_xfer, m_mm, m_latch, m_ovf, m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      q[c].delete();
      seq[c] = 0;
    end
    m_cnt = 0; m_idle = 0; m_ch = 0; m_idx = 0; m_ref = 0; m_dat = 0;
    m_xfer = 0; m_mm = 0; m_latch = 0; m_ovf = 0; m_stall = 0;
  endtask

  task automatic model_step();
    bit pop, all_empty;
    bit wr[CH];
    int fc;
    pop = 1; all_empty = 1;
    for (int c = 0; c < CH; c++) begin
      if (q[c].size() == 0) pop = 0; else all_empty = 0;
      wr[c] = in_tvalid[c] && (q[c].size() < DEPTH);
    end
    m_xfer = pop;
    m_mm = 0;
    if (pop) begin
      fc = -1;
      for (int c = CH - 1; c >= 1; c--) if (q[c][0] != q[0][0]) fc = c;
      if (m_cnt == (1 << CB) - 1) m_ovf = 1;
      m_cnt = (m_cnt + 1) % (1 << CB);
      if (fc >= 0) begin
        m_mm = 1;
        if (!m_latch) begin
          m_latch = 1; m_ch = fc; m_idx = m_cnt; m_ref = q[0][0]; m_dat = q[fc][0];
        end
      end
    end
    if (pop || all_empty) m_idle = 0;
    else if (m_idle < TMO) m_idle++;
    if (m_idle == TMO) m_stall = 1;
    for (int c = 0; c < CH; c++) begin
      if (pop) void'(q[c].pop_front());
      if (wr[c]) begin
        q[c].push_back(dv[c]);
        seq[c]++;
      end
    end
  endtask

  // One clock: drive at negedge, check ready, advance model at posedge, check outputs.
  task automatic run_cycle(input bit rst_v, input int pct, input logic [CH-1:0] idle_mask,
                           input int corrupt_pct);
    logic [CH-1:0] rdy;
    @(negedge clk);
    rst = rst_v;
    if (rst_v) model_reset();
    for (int c = 0; c < CH; c++) begin
      int d;
      d = seq[c] & 16'hffff;
      if (c > 0 && $urandom_range(99) < corrupt_pct) d = d ^ int'($urandom_range(1, 255));
      dv[c] = d;
      in_tvalid[c] = !idle_mask[c] && ($urandom_range(99) < pct);
      in_tdata[c*DB +: DB] = d[DB-1:0];
    end
    #1;
    for (int c = 0; c < CH; c++) rdy[c] = !rst_v && (q[c].size() < DEPTH);
    check("in_tready", 64'(in_tready), 64'(rdy));
    @(posedge clk);
    if (!rst_v) model_step();
    #1;
    check("transfer", 64'(transfer), 64'(m_xfer));
    check("transfer_count", 64'(transfer_count), 64'(m_cnt));
    check("count_overflow", 64'(count_overflow), 64'(m_ovf));
    check("transfer_mismatch", 64'(transfer_mismatch), 64'(m_mm));
    check("mismatch_latch", 64'(transfer_mismatch_latch), 64'(m_latch));
    check("mismatch_channel", 64'(mismatch_channel), 64'(m_ch));
    check("mismatch_index", 64'(mismatch_index), 64'(m_idx));
    check("mismatch_tdata_ref", 64'(mismatch_tdata_ref), 64'(m_ref));
    check("mismatch_tdata", 64'(mismatch_tdata), 64'(m_dat));
    check("stall_timeout", 64'(stall_timeout), 64'(m_stall));
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_tvalid = '0;
    in_tdata = '0;
    model_reset();
    repeat (3) run_cycle(1, 50, 3'b000, 0);
    // Full-rate matched streaming.
    repeat (100) run_cycle(0, 100, 3'b000, 0);
    // Random stalls with occasional corrupted beats on channels 1 and 2.
    repeat (400) run_cycle(0, 75, 3'b000, 3);
    // Mid-stream reset, then long full-rate run that wraps the counter.
    repeat (3) run_cycle(1, 75, 3'b000, 0);
    repeat (300) run_cycle(0, 100, 3'b000, 1);
    check("overflow_after_wrap", 64'(count_overflow), 64'd1);
    // Watchdog: one beat into FIFO 0 only, then count cycles until the flag rises.
    repeat (2) run_cycle(1, 0, 3'b111, 0);
    run_cycle(0, 100, 3'b110, 0);
    n = 0;
    while (!stall_timeout && n < 40) begin
      run_cycle(0, 0, 3'b111, 0);
      n++;
    end
    check("stall_delay", 64'(n), 64'(TMO));
    repeat (30) run_cycle(0, 80, 3'b000, 0);
    check("stall_sticky", 64'(stall_timeout), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
